// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared helpers for the ROM arbiter (index width sizing).
package rom_arbiter_pkg;
  function automatic int clog2(input int v);
    clog2 = 0;
    while ((1 << clog2) < v) clog2++;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational picker, first requester at or after ptr wins (ptr=0 gives fixed priority).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    // scan from farthest to nearest so the nearest valid request overwrites
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one 1-cycle synchronous ROM among NUM_REQ requesters.
// Define ROM_ARBITER_RR_EN for round-robin; otherwise the lowest index wins.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WORD_WIDTH-1:0]         rsp_data_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  output logic                          rom_clke_o,
  input  logic [WORD_WIDTH-1:0]         rom_data_i
);
  localparam int IW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
  logic                  pend_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         idx;
  logic                  rsp_acc;
  logic                  free;
  logic                  grant;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );
  assign rsp_acc     = pend_q && rsp_ready_i[owner_q];
  assign free        = !pend_q || rsp_acc;
  assign grant       = free && !rst_i && |req_valid_i;
  assign req_ready_o = grant ? gnt : '0;
  assign rsp_valid_o = pend_q ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q : '0;
  assign rsp_data_o  = rom_data_i;
  assign rom_clke_o  = rst_i || free;
  assign rom_addr_o  = grant ? req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      owner_q <= '0;
      addr_q  <= '0;
    end else if (grant) begin
      pend_q  <= 1'b1;
      owner_q <= idx;
      addr_q  <= rom_addr_o;
    end else if (rsp_acc) begin
      pend_q  <= 1'b0;
    end
  end
`ifdef ROM_ARBITER_RR_EN
  logic [IW-1:0] ptr_q;
  assign ptr = ptr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else if (grant) ptr_q <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a behavioural ROM.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [8:0]  a0, a1;
  logic [17:0] req_addr;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_ready;
  logic [8:0]  rom_addr;
  logic        rom_clke;
  logic [15:0] rom_q;
  int n_chk = 0;
  int n_err = 0;
  assign req_addr = {a1, a0};
  always #5 clk = ~clk;
  rom_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(9), .WORD_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .rom_addr_o  (rom_addr),
    .rom_clke_o  (rom_clke),
    .rom_data_i  (rom_q)
  );
  function automatic logic [15:0] word(input logic [8:0] a);
    word = (16'(a) * 16'd37) ^ 16'hC3A5;
  endfunction
  always @(posedge clk) if (rom_clke) rom_q <= word(rom_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic [1:0] exp_g, prev_g;
  initial begin
    rst = 1'b1; req_valid = 2'b01; a0 = '0; a1 = '0; rsp_ready = 2'b11;
    cyc();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_clke", 32'(rom_clke), 32'h1);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    req_valid = 2'b00;
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'h0);
    // single read at address 0
    req_valid = 2'b01; a0 = 9'h000;
    #1;
    chk("single_gnt", 32'(req_ready), 32'h1);
    chk("single_addr", 32'(rom_addr), 32'h0);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("single_rsp", 32'(rsp_valid), 32'h1);
    chk("single_data", 32'(rsp_data), 32'(word(9'h000)));
    chk("single_no_gnt", 32'(req_ready), 32'h0);
    cyc();
    chk("single_done", 32'(rsp_valid), 32'h0);
    // stall for three cycles, then accept with a same-cycle grant
    req_valid = 2'b01; a0 = 9'h005; rsp_ready = 2'b00;
    #1;
    chk("stall_gnt", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b10; a1 = 9'h007; rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_clke", 32'(rom_clke), 32'h0);
      chk("stall_no_gnt", 32'(req_ready), 32'h0);
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_data", 32'(rsp_data), 32'(word(9'h005)));
      cyc();
    end
    rsp_ready = 2'b01;
    #1;
    chk("accept_clke", 32'(rom_clke), 32'h1);
    chk("accept_gnt", 32'(req_ready), 32'h2);
    chk("accept_addr", 32'(rom_addr), 32'h7);
    cyc();
    req_valid = 2'b00; rsp_ready = 2'b11;
    #1;
    chk("accept_rsp", 32'(rsp_valid), 32'h2);
    chk("accept_data", 32'(rsp_data), 32'(word(9'h007)));
    cyc();
    // contention: both requesters continuously valid
    a0 = 9'h010; a1 = 9'h020; req_valid = 2'b11; prev_g = 2'b00;
    for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARBITER_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk("cont_gnt", 32'(req_ready), 32'(exp_g));
      chk("cont_rsp", 32'(rsp_valid), 32'(prev_g));
      if (prev_g != 2'b00)
        chk("cont_data", 32'(rsp_data), 32'(word(prev_g == 2'b01 ? a0 : a1)));
      prev_g = exp_g;
      cyc();
    end
    req_valid = 2'b00;
    cyc();
    // reset while requester 1's response is pending
    req_valid = 2'b10; a1 = 9'h030; rsp_ready = 2'b00;
    cyc();
    req_valid = 2'b00; rst = 1'b1;
    #1;
    chk("mid_rsp", 32'(rsp_valid), 32'h2);
    chk("mid_clke", 32'(rom_clke), 32'h1);
    chk("mid_gnt", 32'(req_ready), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_after_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_after_gnt", 32'(req_ready), 32'h0);
    rsp_ready = 2'b11; req_valid = 2'b11;
    #1;
    chk("mid_first_gnt", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("mid_first_data", 32'(rsp_data), 32'(word(9'h010)));
    cyc();
    // back-to-back across the 0x0FF/0x100 boundary
    req_valid = 2'b01; a0 = 9'h0FF;
    #1;
    chk("b2b_gnt0", 32'(req_ready), 32'h1);
    cyc();
    a0 = 9'h100;
    #1;
    chk("b2b_rsp0", 32'(rsp_valid), 32'h1);
    chk("b2b_data0", 32'(rsp_data), 32'(word(9'h0FF)));
    chk("b2b_gnt1", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("b2b_rsp1", 32'(rsp_valid), 32'h1);
    chk("b2b_data1", 32'(rsp_data), 32'(word(9'h100)));
    cyc();
    chk("b2b_idle", 32'(rsp_valid), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous-read ROM (1-cycle registered read, output held while its clock enable is low) between NUM_REQ requesters. Each requester issues addresses over a valid/ready handshake and receives the word over a valid/ready response channel. The block sits between the example application's readers and the ROM instance and owns the ROM's address and clock-enable inputs. When a response is stalled, it freezes the ROM output by dropping clock enable.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- ADDR_WIDTH, 9: ROM address width.
- WORD_WIDTH, 16: ROM word width (8, 16 or 32).
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester read request.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready_o  out  NUM_REQ  one-hot (or zero) grant; request i is accepted when req_valid_i[i] and req_ready_o[i] are both high.
- rsp_valid_o  out  NUM_REQ  one-hot (or zero); response to requester i is valid.
- rsp_data_o  out  WORD_WIDTH  response word; this is rom_data_i passed through.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rom_addr_o  out  ADDR_WIDTH  ROM address.
- rom_clke_o  out  1  ROM clock enable.
- rom_data_i  in  WORD_WIDTH  ROM read data.

## Operation
- State:
  - pend_q: response pending, 1 bit.
  - owner_q: index of the requester that owns the pending response.
  - ptr_q: round-robin pointer, the index with highest priority.
- pend_q and the response channel:
  - rsp_valid_o[i] = pend_q && owner_q==i.
  - Response accepted (rsp_acc) = pend_q && rsp_ready_i[owner_q].
- Slot free when !pend_q || rsp_acc. The free signal is computed in the same cycle, so back-to-back reads issue with no bubble.
- Arbitration:
  - Runs only when the slot is free.
  - Picks one requester among req_valid_i and drives req_ready_o for it only.
  - rom_addr_o = that requester's address.
  - When no requester is valid, rom_addr_o keeps its last granted address.
- rom_clke_o = !pend_q || rsp_acc.
  - When low, the ROM retains its output, so rsp_data_o stays stable while a response is stalled.
- On a grant at edge: pend_q<=1, owner_q<=winner, ptr_q<=winner+1 (mod NUM_REQ).
- On rsp_acc without a new grant: pend_q<=0.
- No request reordering. At most one outstanding read in total.
- Requesters must hold req_addr_i stable while req_valid_i is high and not granted.
- Response handshake rules:
  - The arbiter never withdraws rsp_valid_o before acceptance.
  - rsp_ready_i of non-owners is ignored.

## Timing
- Reset values: pend_q=0, owner_q=0, ptr_q=0, rsp_valid_o=0, req_ready_o=0.
  - rom_clke_o=1 during and after reset; no request is granted in the reset cycle.
- Read latency is 1 cycle: a request granted at edge t gives rsp_valid_o high in the cycle after edge t, with rom_data_i valid in that cycle.
- Throughput is 1 word/cycle when responses are accepted immediately.
- Combinational paths:
  - req_valid_i → req_ready_o
  - rsp_ready_i → req_ready_o
  - rsp_ready_i → rom_clke_o
  - Requesters must not make req_valid_i depend on req_ready_o.
- Reset mid-operation: a pending response is dropped (rsp_valid_o=0 the next cycle) and the pointer returns to 0.
- Simultaneous rsp_acc and a new request from the same requester: the new request is granted in the same cycle.

## Configuration
- ROM_ARBITER_RR_EN defined: round-robin.
  - The first valid index at or after ptr_q wins, wrapping modulo NUM_REQ.
- Undefined: fixed priority.
  - The lowest valid index wins.
  - ptr_q is not implemented, and its update is removed.

## Structure
- Shared package: a clog2 function used for the owner index width.
- One sub-module, rr_arbiter: a combinational picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and index.
  - The fixed-priority variant is the same sub-module with ptr tied to 0.
- Owner and pointer registers stay in rom_arbiter.

## Test plan
- Single read: requester 0 reads addr 0x000 with rsp_ready high.
  - req_ready_o=01 for one cycle.
  - Next cycle rsp_valid_o=01 and rsp_data_o equals the ROM word at 0.
- Stall: rsp_ready_i=0 for 3 cycles after a grant.
  - rom_clke_o=0 and rsp_data_o is constant for those cycles.
  - No further grants.
  - Acceptance on cycle 4 allows a same-cycle grant.
- Contention (RR_EN defined): both requesters are continuously valid with rsp_ready high.
  - Grants alternate 01,10,01,10; 1 word/cycle; each requester's data matches its address.
- Fixed priority (RR_EN undefined), same stimulus: requester 0 receives every grant and requester 1 starves.
- Reset mid-read: rst_i is asserted in the cycle rsp_valid_o=10.
  - Next cycle: rsp_valid_o=0, req_ready_o=0.
  - After reset: the first grant under contention goes to requester 0.
- Back-to-back addresses 0x0FF then 0x100 across the bank boundary: both words are returned correctly on consecutive cycles.
